// File: rtl/ddr4_cmd_tracker.sv
// DDR4 command-bus monitor: decodes CA commands and tracks per-bank open state, open row and tRCD/tRP timing.
// Define DDR4_TRACKER_TRAS_CHECK_EN to add per-bank ACT-to-PRE (tRAS) checking.
module ddr4_cmd_tracker #(
  parameter int RANK_BITS = 1,
  parameter int BG_BITS   = 2,
  parameter int BA_BITS   = 2,
  parameter int ROW_BITS  = 18,
  parameter int TRCD      = 14,
  parameter int TRP       = 14,
  parameter int TRAS      = 32
) (
  input  logic                                        CK_t,
  input  logic                                        RESET_n,
  input  logic                                        CKE,
  input  logic                                        CS_n,
  input  logic                                        ACT_n,
  input  logic                                        RAS_n_A16,
  input  logic                                        CAS_n_A15,
  input  logic                                        WE_n_A14,
  input  logic                                        ADDR_17,
  input  logic [13:0]                                 ADDR,
  input  logic [RANK_BITS-1:0]                        C,
  input  logic [BG_BITS-1:0]                          BG,
  input  logic [BA_BITS-1:0]                          BA,
  output logic                                        cmd_valid,
  output logic [3:0]                                  cmd_code,
  output logic [RANK_BITS-1:0]                        cmd_rank,
  output logic [BG_BITS+BA_BITS-1:0]                  cmd_bank,
  output logic [ROW_BITS-1:0]                         cmd_row,
  output logic                                        err_valid,
  output logic [2:0]                                  err_code,
  output logic [(2**(RANK_BITS+BG_BITS+BA_BITS))-1:0] open_mask
);
  localparam int IW   = RANK_BITS + BG_BITS + BA_BITS;
  localparam int NB   = 2**IW;
  localparam int BPR  = 2**(BG_BITS + BA_BITS);
  localparam int CMAX = (TRCD > TRP) ? TRCD : TRP;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] RCD_LD = CW'(TRCD - 1);
  localparam logic [CW-1:0] RP_LD  = CW'(TRP - 1);
  localparam logic [NB-1:0] RANK0_MASK = {{(NB-BPR){1'b0}}, {BPR{1'b1}}};

  localparam logic [3:0] C_NOP = 4'd0, C_ACT = 4'd1, C_RD = 4'd2, C_WR = 4'd3, C_PRE = 4'd4;
  localparam logic [3:0] C_PREA = 4'd5, C_REF = 4'd6, C_MRS = 4'd7, C_ZQC = 4'd8;
  localparam logic [2:0] E_CLOSED = 3'd1, E_ACT_OPEN = 3'd2, E_TRCD = 3'd3, E_TRP = 3'd4;
  localparam logic [2:0] E_REF = 3'd5, E_TRAS = 3'd6;

  logic                hit;
  logic [3:0]          code;
  logic [IW-1:0]       sel;
  logic [17:0]         addr_full;
  logic [ROW_BITS-1:0] act_row;
  logic [ROW_BITS-1:0] row_out;
  logic [NB-1:0]       rank_mask;
  logic [NB-1:0]       open_q, open_d, close_mask, tras_busy;
  logic [ROW_BITS-1:0] row_q [NB];
  logic [CW-1:0]       cnt_q [NB];
  logic [CW-1:0]       cnt_d [NB];
  logic [2:0]          err_d;

  assign hit       = CKE & ~CS_n;
  assign sel       = {C, BG, BA};
  assign addr_full = {ADDR_17, RAS_n_A16, CAS_n_A15, WE_n_A14, ADDR};
  assign act_row   = addr_full[ROW_BITS-1:0];
  assign rank_mask = RANK0_MASK << {C, {(BG_BITS+BA_BITS){1'b0}}};
  assign open_mask = open_q;

  always_comb begin
    code = C_NOP;
    if (!ACT_n) code = C_ACT;
    else begin
      case ({RAS_n_A16, CAS_n_A15, WE_n_A14})
        3'b000:  code = C_MRS;
        3'b001:  code = C_REF;
        3'b010:  code = ADDR[10] ? C_PREA : C_PRE;
        3'b101:  code = C_RD;
        3'b100:  code = C_WR;
        3'b110:  code = C_ZQC;
        default: code = C_NOP;
      endcase
    end
  end

`ifdef DDR4_TRACKER_TRAS_CHECK_EN
  localparam int TW = $clog2(TRAS + 1);
  localparam logic [TW-1:0] RAS_LD = TW'(TRAS - 1);
  logic [TW-1:0] tras_q [NB];
  logic [TW-1:0] tras_d [NB];

  always_comb begin
    for (int i = 0; i < NB; i++) begin
      tras_busy[i] = (tras_q[i] != '0);
      tras_d[i]    = tras_busy[i] ? tras_q[i] - TW'(1) : '0;
    end
    if (hit && code == C_ACT) tras_d[sel] = RAS_LD;
  end

  always_ff @(posedge CK_t or negedge RESET_n) begin
    if (!RESET_n) for (int i = 0; i < NB; i++) tras_q[i] <= '0;
    else          for (int i = 0; i < NB; i++) tras_q[i] <= tras_d[i];
  end
`else
  logic unused_tras;
  assign tras_busy   = '0;
  assign unused_tras = ^TRAS;
`endif

  // close_mask collects banks that go from open to closed this cycle (PRE, PREA, auto-precharge)
  always_comb begin
    open_d     = open_q;
    close_mask = '0;
    err_d      = 3'd0;
    for (int i = 0; i < NB; i++) cnt_d[i] = (cnt_q[i] != '0) ? cnt_q[i] - CW'(1) : '0;
    if (hit) begin
      case (code)
        C_ACT: begin
          if (open_q[sel])           err_d = E_ACT_OPEN;
          else if (cnt_q[sel] != '0) err_d = E_TRP;
          open_d[sel] = 1'b1;
          cnt_d[sel]  = RCD_LD;
        end
        C_RD, C_WR: begin
          if (!open_q[sel]) err_d = E_CLOSED;
          else begin
            if (cnt_q[sel] != '0) err_d = E_TRCD;
            if (ADDR[10]) close_mask[sel] = 1'b1;
          end
        end
        C_PRE:   close_mask[sel] = open_q[sel];
        C_PREA:  close_mask = open_q & rank_mask;
        C_REF:   if (|(open_q & rank_mask)) err_d = E_REF;
        default: ;
      endcase
      for (int i = 0; i < NB; i++) begin
        if (close_mask[i]) begin
          open_d[i] = 1'b0;
          cnt_d[i]  = RP_LD;
        end
      end
      if (err_d == 3'd0 && |(close_mask & tras_busy)) err_d = E_TRAS;
    end
  end

  always_comb begin
    row_out = '0;
    if (hit && code == C_ACT)                    row_out = act_row;
    else if (hit && (code == C_RD || code == C_WR)) row_out = row_q[sel];
  end

  always_ff @(posedge CK_t or negedge RESET_n) begin
    if (!RESET_n) begin
      open_q    <= '0;
      cmd_valid <= 1'b0;
      cmd_code  <= '0;
      cmd_rank  <= '0;
      cmd_bank  <= '0;
      cmd_row   <= '0;
      err_valid <= 1'b0;
      err_code  <= '0;
      for (int i = 0; i < NB; i++) begin
        row_q[i] <= '0;
        cnt_q[i] <= '0;
      end
    end else begin
      open_q <= open_d;
      for (int i = 0; i < NB; i++) cnt_q[i] <= cnt_d[i];
      if (hit && code == C_ACT) row_q[sel] <= act_row;
      cmd_valid <= hit;
      cmd_code  <= hit ? code : C_NOP;
      cmd_rank  <= hit ? C : '0;
      cmd_bank  <= hit ? {BG, BA} : '0;
      cmd_row   <= row_out;
      err_valid <= (err_d != 3'd0);
      err_code  <= err_d;
    end
  end
endmodule

// File: tb/tb_ddr4_cmd_tracker.sv
// Bench for ddr4_cmd_tracker: directed protocol cases with literal expectations, then random traffic
// scored against a timestamp-based bank model through an expected queue.
`timescale 1ns/1ps
module tb_ddr4_cmd_tracker;
  localparam int NB   = 32;
  localparam int TRCD = 14;
  localparam int TRP  = 14;
  localparam int TRAS = 32;
`ifdef DDR4_TRACKER_TRAS_CHECK_EN
  localparam bit TRAS_EN = 1'b1;
`else
  localparam bit TRAS_EN = 1'b0;
`endif
  localparam int K_NOP = 0, K_ACT = 1, K_RD = 2, K_WR = 3, K_PRE = 4;
  localparam int K_PREA = 5, K_REF = 6, K_MRS = 7, K_ZQC = 8;

  logic        CK_t = 1'b0, RESET_n = 1'b0, CKE = 1'b0, CS_n = 1'b1, ACT_n = 1'b1;
  logic        RAS_n_A16 = 1'b1, CAS_n_A15 = 1'b1, WE_n_A14 = 1'b1, ADDR_17 = 1'b0;
  logic [13:0] ADDR = '0;
  logic [0:0]  C = '0;
  logic [1:0]  BG = '0, BA = '0;
  logic        cmd_valid, err_valid;
  logic [3:0]  cmd_code, cmd_bank;
  logic [0:0]  cmd_rank;
  logic [17:0] cmd_row;
  logic [2:0]  err_code;
  logic [31:0] open_mask;

  int checks = 0;
  int errors = 0;

  ddr4_cmd_tracker #(.RANK_BITS(1), .BG_BITS(2), .BA_BITS(2), .ROW_BITS(18),
                     .TRCD(TRCD), .TRP(TRP), .TRAS(TRAS)) dut (
    .CK_t(CK_t), .RESET_n(RESET_n), .CKE(CKE), .CS_n(CS_n), .ACT_n(ACT_n),
    .RAS_n_A16(RAS_n_A16), .CAS_n_A15(CAS_n_A15), .WE_n_A14(WE_n_A14), .ADDR_17(ADDR_17),
    .ADDR(ADDR), .C(C), .BG(BG), .BA(BA),
    .cmd_valid(cmd_valid), .cmd_code(cmd_code), .cmd_rank(cmd_rank), .cmd_bank(cmd_bank),
    .cmd_row(cmd_row), .err_valid(err_valid), .err_code(err_code), .open_mask(open_mask)
  );

  // clock / reset
  always #5 CK_t = ~CK_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model: bank state plus the cycle at which each bank's timing window expires
  bit          open_m [NB];
  logic [17:0] row_m [NB];
  longint      ready_m [NB];
  longint      tras_m [NB];
  longint      cyc = 0;
  logic [63:0] exp_q [$];
  logic [63:0] cur;

  function automatic logic [63:0] model_step();
    int kind, b, base, err;
    bit v, any6;
    logic [17:0] r;
    logic [31:0] m;
    kind = K_NOP; err = 0; v = 1'b0; r = '0; any6 = 1'b0; m = '0;
    b    = int'(C) * 16 + int'(BG) * 4 + int'(BA);
    base = int'(C) * 16;
    if (!RESET_n) begin
      for (int i = 0; i < NB; i++) begin
        open_m[i] = 1'b0; row_m[i] = '0; ready_m[i] = 0; tras_m[i] = 0;
      end
      cyc++;
      return '0;
    end
    if (CKE && !CS_n) begin
      v = 1'b1;
      if (!ACT_n) kind = K_ACT;
      else begin
        case ({RAS_n_A16, CAS_n_A15, WE_n_A14})
          3'b000:  kind = K_MRS;
          3'b001:  kind = K_REF;
          3'b010:  kind = ADDR[10] ? K_PREA : K_PRE;
          3'b101:  kind = K_RD;
          3'b100:  kind = K_WR;
          3'b110:  kind = K_ZQC;
          default: kind = K_NOP;
        endcase
      end
      case (kind)
        K_ACT: begin
          r = {ADDR_17, RAS_n_A16, CAS_n_A15, WE_n_A14, ADDR};
          if (open_m[b]) err = 2;
          else if (cyc < ready_m[b]) err = 4;
          open_m[b] = 1'b1; row_m[b] = r; ready_m[b] = cyc + TRCD; tras_m[b] = cyc + TRAS;
        end
        K_RD, K_WR: begin
          r = row_m[b];
          if (!open_m[b]) err = 1;
          else begin
            if (cyc < ready_m[b]) err = 3;
            if (ADDR[10]) begin
              open_m[b] = 1'b0; ready_m[b] = cyc + TRP;
              if (TRAS_EN && err == 0 && cyc < tras_m[b]) err = 6;
            end
          end
        end
        K_PRE: if (open_m[b]) begin
          open_m[b] = 1'b0; ready_m[b] = cyc + TRP;
          if (TRAS_EN && cyc < tras_m[b]) err = 6;
        end
        K_PREA: begin
          for (int j = 0; j < 16; j++) begin
            if (open_m[base+j]) begin
              open_m[base+j] = 1'b0; ready_m[base+j] = cyc + TRP;
              if (cyc < tras_m[base+j]) any6 = 1'b1;
            end
          end
          if (TRAS_EN && any6) err = 6;
        end
        K_REF: for (int j = 0; j < 16; j++) if (open_m[base+j]) err = 5;
        default: ;
      endcase
    end
    for (int j = 0; j < NB; j++) m[j] = open_m[j];
    cyc++;
    return {v, 4'(kind), C, BG, BA, r, (err != 0), 3'(err), m};
  endfunction

  always @(posedge CK_t) exp_q.push_back(model_step());

  // scoreboard: one entry per sampling edge, checked on the following falling edge
  always @(negedge CK_t) begin
    if (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
      chk("cmd_valid", 64'(cmd_valid), 64'(cur[63]));
      if (cur[63]) begin
        chk("cmd_code", 64'(cmd_code), 64'(cur[62:59]));
        chk("cmd_rank", 64'(cmd_rank), 64'(cur[58]));
        chk("cmd_bank", 64'(cmd_bank), 64'(cur[57:54]));
        if (cur[62:59] inside {4'd1, 4'd2, 4'd3}) chk("cmd_row", 64'(cmd_row), 64'(cur[53:36]));
      end
      chk("err_valid", 64'(err_valid), 64'(cur[35]));
      if (cur[35]) chk("err_code", 64'(err_code), 64'(cur[34:32]));
      chk("open_mask", 64'(open_mask), 64'(cur[31:0]));
    end
  end

  // drivers
  task automatic send(input int kind, input int rank, input int bg, input int ba,
                      input logic [17:0] row, input bit a10);
    logic [13:0] a;
    a = 14'($urandom);
    a[10] = a10;
    CKE = 1'b1; CS_n = 1'b0; C = 1'(rank); BG = 2'(bg); BA = 2'(ba);
    if (kind == K_ACT) begin
      ACT_n = 1'b0;
      {ADDR_17, RAS_n_A16, CAS_n_A15, WE_n_A14, ADDR} = row;
    end else begin
      ACT_n = 1'b1; ADDR_17 = 1'($urandom);
      case (kind)
        K_MRS:   {RAS_n_A16, CAS_n_A15, WE_n_A14} = 3'b000;
        K_REF:   {RAS_n_A16, CAS_n_A15, WE_n_A14} = 3'b001;
        K_PRE:   begin {RAS_n_A16, CAS_n_A15, WE_n_A14} = 3'b010; a[10] = 1'b0; end
        K_PREA:  begin {RAS_n_A16, CAS_n_A15, WE_n_A14} = 3'b010; a[10] = 1'b1; end
        K_RD:    {RAS_n_A16, CAS_n_A15, WE_n_A14} = 3'b101;
        K_WR:    {RAS_n_A16, CAS_n_A15, WE_n_A14} = 3'b100;
        K_ZQC:   {RAS_n_A16, CAS_n_A15, WE_n_A14} = 3'b110;
        default: {RAS_n_A16, CAS_n_A15, WE_n_A14} = 3'b111;
      endcase
      ADDR = a;
    end
    @(negedge CK_t);
  endtask

  task automatic idle(input int n);
    repeat (n) send(K_NOP, 0, 0, 0, 18'h0, 1'b0);
  endtask

  task automatic des();
    CKE = 1'b1; CS_n = 1'b1; ACT_n = 1'($urandom); ADDR = 14'($urandom);
    {RAS_n_A16, CAS_n_A15, WE_n_A14} = 3'($urandom);
    @(negedge CK_t);
  endtask

  task automatic cke_low();
    CKE = 1'b0; CS_n = 1'b0; ACT_n = 1'b0; ADDR = 14'($urandom);
    @(negedge CK_t);
  endtask

  task automatic mid_reset();
    #2 RESET_n = 1'b0;
    #1;
    chk("rst_cmd_valid", 64'(cmd_valid), 64'd0);
    chk("rst_err_valid", 64'(err_valid), 64'd0);
    chk("rst_open_mask", 64'(open_mask), 64'd0);
    chk("rst_cmd_code", 64'(cmd_code), 64'd0);
    @(negedge CK_t);
    @(negedge CK_t);
    #2 RESET_n = 1'b1;
    @(negedge CK_t);
  endtask

  initial begin
    int p, rk, bg, ba;
    repeat (3) @(negedge CK_t);
    chk("reset_cmd_valid", 64'(cmd_valid), 64'd0);
    chk("reset_err_valid", 64'(err_valid), 64'd0);
    chk("reset_open_mask", 64'(open_mask), 64'd0);
    chk("reset_cmd_row", 64'(cmd_row), 64'd0);
    #2 RESET_n = 1'b1;
    @(negedge CK_t);

    // ACT, wait out tRCD, read
    send(K_ACT, 0, 1, 2, 18'h1ABC, 1'b0);
    chk("a_act_code", 64'(cmd_code), 64'd1);
    chk("a_act_row", 64'(cmd_row), 64'h1ABC);
    chk("a_act_mask", 64'(open_mask), 64'h40);
    idle(14);
    send(K_RD, 0, 1, 2, 18'h0, 1'b0);
    chk("a_rd_code", 64'(cmd_code), 64'd2);
    chk("a_rd_row", 64'(cmd_row), 64'h1ABC);
    chk("a_rd_err", 64'(err_valid), 64'd0);

    // tRCD violation
    send(K_ACT, 0, 0, 1, 18'h0123, 1'b0);
    idle(4);
    send(K_RD, 0, 0, 1, 18'h0, 1'b0);
    chk("b_trcd_err", 64'(err_valid), 64'd1);
    chk("b_trcd_code", 64'(err_code), 64'd3);
    chk("b_mask", 64'(open_mask), 64'h42);

    // access to a closed bank
    send(K_RD, 1, 3, 3, 18'h0, 1'b0);
    chk("c_closed_code", 64'(err_code), 64'd1);
    chk("c_mask", 64'(open_mask), 64'h42);

    // PREA then early ACT
    send(K_ACT, 0, 0, 0, 18'h00055, 1'b0);
    send(K_ACT, 0, 0, 3, 18'h00077, 1'b0);
    chk("d_mask_open", 64'(open_mask), 64'h4B);
    send(K_PREA, 0, 0, 0, 18'h0, 1'b1);
    chk("d_prea_mask", 64'(open_mask), 64'h0);
    chk("d_prea_err", 64'(err_valid), 64'(TRAS_EN));
    idle(2);
    send(K_ACT, 0, 0, 0, 18'h00099, 1'b0);
    chk("d_trp_code", 64'(err_code), 64'd4);
    chk("d_trp_mask", 64'(open_mask), 64'h1);

    // REF with open bank, CKE low
    send(K_ACT, 0, 1, 1, 18'h2F00F, 1'b0);
    send(K_REF, 0, 0, 0, 18'h0, 1'b0);
    chk("e_ref_code", 64'(err_code), 64'd5);
    cke_low();
    chk("e_cke_valid", 64'(cmd_valid), 64'd0);
    chk("e_cke_mask", 64'(open_mask), 64'h21);

    // early PRE: tRAS
    send(K_ACT, 0, 0, 2, 18'h00321, 1'b0);
    idle(9);
    send(K_PRE, 0, 0, 2, 18'h0, 1'b0);
    chk("f_tras_err", 64'(err_valid), 64'(TRAS_EN));
    if (TRAS_EN) chk("f_tras_code", 64'(err_code), 64'd6);

    // random traffic over a small bank set so open/closed/timing interactions are frequent
    for (int it = 0; it < 3000; it++) begin
      if (it == 1500) mid_reset();
      p  = $urandom_range(0, 99);
      rk = $urandom_range(0, 1);
      bg = $urandom_range(0, 1);
      ba = $urandom_range(0, 1);
      if (p < 22)      send(K_ACT, rk, bg, ba, 18'($urandom), 1'b0);
      else if (p < 34) send(K_RD, rk, bg, ba, 18'h0, 1'($urandom_range(0, 1)));
      else if (p < 46) send(K_WR, rk, bg, ba, 18'h0, 1'($urandom_range(0, 1)));
      else if (p < 57) send(K_PRE, rk, bg, ba, 18'h0, 1'b0);
      else if (p < 61) send(K_PREA, rk, bg, ba, 18'h0, 1'b1);
      else if (p < 65) send(K_REF, rk, bg, ba, 18'h0, 1'b0);
      else if (p < 68) send(K_MRS, rk, bg, ba, 18'h0, 1'b0);
      else if (p < 71) send(K_ZQC, rk, bg, ba, 18'h0, 1'b0);
      else if (p < 80) idle($urandom_range(1, 16));
      else if (p < 92) des();
      else             cke_low();
    end
    des();
    des();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ddr4_cmd_tracker.md
Name: ddr4_cmd_tracker

Overview:
Parametrised DDR4 command-bus monitor for the memory-model testbench.
- Samples the CA bundle on every CK_t rising edge.
- Decodes each command and tracks the open/closed state and open row of every bank across all ranks.
- Checks basic activate-to-access (tRCD) and precharge-to-activate (tRP) timing with per-bank counters.
- Emits a registered decoded-command stream and an error stream, for scoreboards and protocol assertions.

Parameters:
RANK_BITS, 1, width of C (rank select); ranks = 2**RANK_BITS
BG_BITS, 2, bank-group bits; groups = 2**BG_BITS
BA_BITS, 2, bank-address bits per group
ROW_BITS, 18, stored row width, ROW_BITS <= 18
TRCD, 14, ACT-to-RD/WR minimum in CK cycles (>= 1)
TRP, 14, PRE-to-ACT minimum in CK cycles (>= 1)
TRAS, 32, ACT-to-PRE minimum in CK cycles (used only with optional feature)

Ports:
CK_t  in  1  command clock; all state updates on the rising edge
RESET_n  in  1  asynchronous, active-low reset
CKE  in  1  clock enable; commands ignored when low
CS_n  in  1  chip select, active low
ACT_n  in  1  activate, active low
RAS_n_A16  in  1  RAS_n / row bit 16
CAS_n_A15  in  1  CAS_n / row bit 15
WE_n_A14  in  1  WE_n / row bit 14
ADDR_17  in  1  row bit 17
ADDR  in  14  address A[13:0]; A10 = auto-precharge / precharge-all
C  in  RANK_BITS  rank select
BG  in  BG_BITS  bank group
BA  in  BA_BITS  bank address
cmd_valid  out  1  decoded command valid (single-cycle pulse)
cmd_code  out  4  0 NOP/DES, 1 ACT, 2 RD, 3 WR, 4 PRE, 5 PREA, 6 REF, 7 MRS, 8 ZQC
cmd_rank  out  RANK_BITS  rank of command
cmd_bank  out  BG_BITS+BA_BITS  {BG,BA}
cmd_row  out  ROW_BITS  ACT: new row; RD/WR: currently open row
err_valid  out  1  protocol error pulse
err_code  out  3  1 access to closed bank, 2 ACT to open bank, 3 tRCD, 4 tRP, 5 REF with open bank, 6 tRAS
open_mask  out  2**(RANK_BITS+BG_BITS+BA_BITS)  bit per bank, 1 = open; index {rank,BG,BA}

Behaviour:
- Reset (async assert, sync release): all outputs 0, all banks closed, all timing counters 0.
- A command is a rising edge with CKE=1 and CS_n=0. Otherwise DES: no state change, cmd_valid=0.
- Decode:
  - ACT_n=0 -> ACT; row = {ADDR_17,RAS_n_A16,CAS_n_A15,WE_n_A14,ADDR}[ROW_BITS-1:0].
  - ACT_n=1, {RAS,CAS,WE}: LLL MRS, LLH REF, LHL PRE (A10=1 -> PREA), HLH RD, HLL WR, HHL ZQC, HHH NOP.
- Latency: cmd_* and err_* are registered and valid exactly 1 cycle after the sampling edge. cmd_valid=1 for every non-DES command, including NOP.
- Per-bank state: open bit, row register, timing counter.
  - ACT loads the counter with TRCD-1; PRE/PREA loads it with TRP-1.
  - Counter decrements every cycle while nonzero and saturates at 0.
- ACT on a closed bank: bank opens, row stored. If counter != 0 -> err 4.
- ACT on an open bank: err 2; row is still overwritten and counter reloaded.
- RD/WR on a closed bank: err 1, no state change. RD/WR on an open bank with counter != 0: err 3.
- RD/WR with A10=1 (auto-precharge): bank closes after the access; counter loaded with TRP-1.
- PRE on a closed bank: legal, no error, counter unaffected. PREA: closes every bank of the rank; counters loaded only for banks that were open.
- REF with any bank of the rank open: err 5. REF never changes bank state.
- Only one error per command. Priority: 1/2 > 3/4 > 6.
- open_mask reflects state after the previous command (registered).
- RESET_n asserted mid-command: immediate clear, no output pulse.

Optional Feature:
DDR4_TRACKER_TRAS_CHECK_EN
- Defined: a second per-bank counter is loaded with TRAS-1 on ACT. PRE, PREA or auto-precharge closing a bank while that counter is nonzero raises err 6, lowest priority. For PREA, any offending bank raises err 6.
- Undefined: no tRAS counters, TRAS is unused, err 6 is never produced.

Test Plan:
- Reset, then ACT r0 bg1 ba2 row 0x1ABC; 14 NOPs; RD same bank -> cmd_code 1 then 2, cmd_row 0x1ABC, open_mask bit 6 set, no err.
- ACT then RD 5 cycles later (TRCD=14) -> err_valid with err_code 3 on the RD response cycle; bank remains open.
- RD to a never-activated bank -> err_code 1, open_mask unchanged.
- ACT banks 0 and 3, PREA (A10=1), ACT bank 0 after 3 cycles -> open_mask 0 after PREA, then err_code 4.
- ACT bank 5, REF same rank -> err_code 5; CKE=0 with a valid ACT -> no cmd_valid.
- Macro defined, TRAS=32: ACT, PRE after 10 cycles -> err_code 6. Macro undefined: same stimulus -> no error.
